// File: rtl/reg_write_arbiter_if.sv
// Bus between four write requesters and the shared-register arbiter.
// The requesters drive the master side. The arbiter drives the slave side.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data;
  logic [3:0]         grant;
  logic [3:0]         ack;
  logic               enable;
  logic [WIDTH-1:0]   q;
  logic [1:0]         q_owner;
  logic               busy;

  modport master (
    output req, data,
    input  grant, ack, enable, q, q_owner, busy
  );

  modport slave (
    input  req, data,
    output grant, ack, enable, q, q_owner, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Four-way arbiter for writes to one shared register.
// State updates on the falling edge of clock. resetn is an asynchronous,
// active-low reset.
// Each transfer runs IDLE -> WRITE -> ACK -> IDLE:
//   - IDLE picks a winner from the pending requests.
//   - WRITE loads the winner's data slice into q.
//   - ACK pulses the winner's ack for one cycle.
// Arbitration policy:
//   - REG_ARB_RR_EN defined: round-robin. The rotating pointer moves to
//     winner+1 after each write.
//   - REG_ARB_RR_EN undefined: fixed priority. req[0] is highest.
module reg_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               resetn,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       winner;
  logic [1:0]       pick;
  logic             any_req;
  logic [WIDTH-1:0] q_r;
  logic [1:0]       q_owner_r;
  logic [3:0]       grant_c;
  logic [3:0]       ack_c;
  logic             enable_c;
  logic             busy_c;

`ifdef REG_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] rr_idx;
`endif

  assign any_req = |bus.req;

  // Winner selection from the current request vector.
  // The policy is chosen at build time.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pick = 2'd0;
`ifdef REG_ARB_RR_EN
    rr_idx = 2'd0;
    // Scan from the farthest offset back to the pointer. The last hit is
    // the one nearest the pointer, going upward and wrapping 3 to 0.
    for (int k = 3; k >= 0; k--) begin
      rr_idx = 2'(int'(ptr) + k);
      if (bus.req[rr_idx]) pick = rr_idx;
    end
`else
    // Scan downward so that the lowest requesting index wins.
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[k]) pick = 2'(k);
    end
`endif
  end

  // FSM state register.
  always_ff @(negedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments. Every
    // register then samples pre-edge values, whatever the block order.
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and the handshake outputs.
  always_comb begin
    state_nxt = S_IDLE;
    grant_c   = 4'b0000;
    ack_c     = 4'b0000;
    enable_c  = 1'b0;
    busy_c    = (state != S_IDLE);
    case (state)
      S_IDLE:  state_nxt = any_req ? S_WRITE : S_IDLE;
      S_WRITE: begin
        grant_c   = 4'b0001 << winner;
        enable_c  = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        ack_c     = 4'b0001 << winner;
        state_nxt = S_IDLE;
      end
      // The unused encoding falls back to IDLE through the default above.
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers:
  //   - The winner is latched when leaving IDLE.
  //   - q, q_owner and the pointer are loaded at the WRITE closing edge.
  always_ff @(negedge clock or negedge resetn) begin
    // NOTE: q is a single register, not a memory array, so it is cleared
    // here. A reset that aborts a transfer must leave q at 0.
    if (!resetn) begin
      winner    <= 2'd0;
      q_r       <= '0;
      q_owner_r <= 2'd0;
`ifdef REG_ARB_RR_EN
      ptr       <= 2'd0;
`endif
    end else begin
      if (state == S_IDLE && any_req) winner <= pick;
      if (state == S_WRITE) begin
        q_r       <= bus.data[WIDTH*int'(winner) +: WIDTH];
        q_owner_r <= winner;
`ifdef REG_ARB_RR_EN
        ptr       <= winner + 2'd1;
`endif
      end
    end
  end

  assign bus.grant   = grant_c;
  assign bus.ack     = ack_c;
  assign bus.enable  = enable_c;
  assign bus.busy    = busy_c;
  assign bus.q       = q_r;
  assign bus.q_owner = q_owner_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter.
//
// Reference model: a transaction-level model.
//   - It counts the two busy cycles that follow each grant.
//   - It picks winners from the arbitration rules: lowest index, or
//     round-robin from a pointer when REG_ARB_RR_EN is defined.
//   - It records each expected write in a scoreboard queue.
//
// Checking:
//   - A monitor compares the DUT outputs against the model every cycle.
//   - The monitor pops the scoreboard whenever an ack is presented.
module tb_reg_write_arbiter;

  localparam int W = 8;

  logic clock;
  logic resetn;

  reg_write_arbiter_if #(.WIDTH(W)) bus ();

  reg_write_arbiter #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] w;
    logic [7:0] d;
  } sb_t;

  sb_t        sb[$];
  int         remain  = 0;   // busy cycles left in the current transfer
  logic [1:0] m_win   = 0;
  logic [7:0] m_q     = 0;
  logic [1:0] m_owner = 0;
  int         m_ptr   = 0;

  function automatic logic [1:0] model_pick(input logic [3:0] r, input int p);
`ifdef REG_ARB_RR_EN
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return 2'((p + off) % 4);
    return 2'd0;
`else
    for (int i = 0; i < 4; i++)
      if (r[i]) return 2'(i);
    return 2'd0;
`endif
  endfunction

  always @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      remain  = 0;
      m_q     = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_win   = 0;
      sb.delete();
    end else if (remain == 2) begin
      sb_t e;
      m_q     = bus.data[int'(m_win)*W +: W];
      m_owner = m_win;
`ifdef REG_ARB_RR_EN
      m_ptr   = (int'(m_win) + 1) % 4;
`endif
      e.w = m_win;
      e.d = m_q;
      sb.push_back(e);
      remain = 1;
    end else if (remain == 1) begin
      remain = 0;
    end else if (bus.req != 4'b0000) begin
      m_win  = model_pick(bus.req, m_ptr);
      remain = 2;
    end
  end

  // ---------------- monitor ----------------
  logic [3:0] exp_grant, exp_ack;
  sb_t        popped;

  always @(posedge clock) begin
    exp_grant = (remain == 2) ? (4'b0001 << m_win) : 4'b0000;
    exp_ack   = (remain == 1) ? (4'b0001 << m_owner) : 4'b0000;
    check("grant",   32'(bus.grant),   32'(exp_grant));
    check("ack",     32'(bus.ack),     32'(exp_ack));
    check("enable",  32'(bus.enable),  32'(remain == 2));
    check("busy",    32'(bus.busy),    32'(remain != 0));
    check("q",       32'(bus.q),       32'(m_q));
    check("q_owner", 32'(bus.q_owner), 32'(m_owner));
    if (bus.ack != 4'b0000) begin
      if (sb.size() == 0) begin
        check("ack_without_write", 32'(bus.ack), 32'h0);
      end else begin
        popped = sb.pop_front();
        check("sb_ack",   32'(bus.ack),     32'(4'b0001 << popped.w));
        check("sb_q",     32'(bus.q),       32'(popped.d));
        check("sb_owner", 32'(bus.q_owner), 32'(popped.w));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] r, input logic [31:0] d);
    @(posedge clock);
    #1;
    bus.req  = r;
    bus.data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},   32'(bus.grant),   32'h0);
    check({tag, "_ack"},     32'(bus.ack),     32'h0);
    check({tag, "_enable"},  32'(bus.enable),  32'h0);
    check({tag, "_busy"},    32'(bus.busy),    32'h0);
    check({tag, "_q"},       32'(bus.q),       32'h0);
    check({tag, "_q_owner"}, 32'(bus.q_owner), 32'h0);
  endtask

  logic [3:0]  r, a, g;
  logic [31:0] d;
  int          budget;

  initial begin
    resetn   = 1'b0;
    bus.req  = 4'b0000;
    bus.data = '0;
    idle(2);
    #1 check_reset_outputs("reset");
    @(posedge clock);
    #1 resetn = 1'b1;

    // Single request from requester 2.
    drive(4'b0100, 32'h00A5_0000);
    idle(1);
    drive(4'b0000, 32'h00A5_0000);
    idle(3);
    check("single_q", 32'(bus.q), 32'hA5);
    check("single_owner", 32'(bus.q_owner), 32'd2);

    // No requests for 20 cycles: q must hold.
    idle(20);
    check("idle_q_hold", 32'(bus.q), 32'hA5);

    // All requesters held high.
    drive(4'b1111, 32'h1312_1110);
    idle(16);
    drive(4'b0000, 32'h0);
    idle(4);

    // Wrap-around. A single request from 2 leaves the pointer at 3,
    // then 4'b1001 is held.
    drive(4'b0100, 32'h0077_0000);
    idle(1);
    drive(4'b0000, 32'h0);
    idle(3);
    drive(4'b1001, 32'hC300_003C);
    idle(7);
    drive(4'b0000, 32'h0);
    idle(4);

    // The winner drops its request during WRITE.
    drive(4'b0010, 32'h0000_5A00);
    drive(4'b0000, 32'h0000_5A00);
    idle(6);
    check("drop_q", 32'(bus.q), 32'h5A);

    // Reset in the middle of WRITE with data 8'hFF.
    drive(4'b0001, 32'h0000_00FF);
    budget = 0;
    while (bus.grant == 4'b0000 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    check("reset_mid_write_reached_write", 32'(bus.grant), 32'h1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("abort");
    @(posedge clock);
    #1 resetn = 1'b1;
    idle(6);
    check("after_reset_q", 32'(bus.q), 32'hFF);
    drive(4'b0000, 32'h0);
    idle(4);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      a = bus.ack;
      g = bus.grant;
      r = bus.req;
      d = bus.data;
      for (int i = 0; i < 4; i++) begin
        if (r[i]) begin
          if (a[i]) begin
            if ($urandom_range(1) == 0) r[i] = 1'b0;
            else d[i*8 +: 8] = 8'($urandom);
          end else if (g[i] && $urandom_range(7) == 0) begin
            r[i] = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          r[i] = 1'b1;
          d[i*8 +: 8] = 8'($urandom);
        end
      end
      #1;
      bus.req  = r;
      bus.data = d;
    end
    drive(4'b0000, 32'h0);
    idle(5);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
